// File: rtl/ifft_pkg.sv
// Shared constants, complex sample type and index bit-reversal for the IFFT output stage.
package ifft_pkg;

    localparam int unsigned IFFT_N    = 32;
    localparam int unsigned IFFT_LOGN = 5;
    localparam int unsigned IFFT_DW   = 29;

    typedef struct packed {
        logic [IFFT_DW-1:0] re;
        logic [IFFT_DW-1:0] im;
    } cplx_t;

    // Mirror the 5 index bits: the IFFT emits sample k at natural position bitrev5(k).
    function automatic logic [IFFT_LOGN-1:0] bitrev5(input logic [IFFT_LOGN-1:0] x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

endpackage

// File: rtl/ifft_bitrev_reorder_if.sv
// Input and output sample streams of the bit-reversal reorder stage.
interface ifft_bitrev_reorder_if;
    import ifft_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [IFFT_DW-1:0]   in_re;
    logic [IFFT_DW-1:0]   in_im;
    logic                 out_valid;
    logic                 out_ready;
    logic [IFFT_DW-1:0]   out_re;
    logic [IFFT_DW-1:0]   out_im;
    logic [IFFT_LOGN-1:0] out_idx;
    logic                 out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last
    );

endinterface

// File: rtl/ifft_pp_bank.sv
// One half of the ping-pong buffer: a frame of complex samples plus its full flag.
module ifft_pp_bank
    import ifft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [IFFT_LOGN-1:0] i_waddr,
    input  cplx_t                i_wdata,
    input  logic                 i_set_full,
    input  logic                 i_clr_full,
    input  logic [IFFT_LOGN-1:0] i_raddr,
    output cplx_t                o_rdata,
    output logic                 o_full
);

    cplx_t r_mem [IFFT_N];
    logic  r_full;

    // Sample storage carries no reset; the full flag alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
        end else if (i_set_full) begin
            r_full <= 1'b1;
        end else if (i_clr_full) begin
            r_full <= 1'b0;
        end
    end

    assign o_rdata = r_mem[i_raddr];
    assign o_full  = r_full;

endmodule

// File: rtl/ifft_bitrev_reorder.sv
// Reorders bit-reversed 32-point IFFT frames into natural order through a ping-pong buffer.
module ifft_bitrev_reorder
    import ifft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    ifft_bitrev_reorder_if.slave  bus
);

    localparam int unsigned LOGN = IFFT_LOGN;
    localparam int unsigned N    = IFFT_N;

    logic            r_wbank;
    logic            r_rbank;
    logic [LOGN-1:0] r_wcnt;
    logic [LOGN-1:0] r_rcnt;

    logic [1:0]      w_full;
    logic [1:0]      w_we;
    logic [1:0]      w_set;
    logic [1:0]      w_clr;
    cplx_t           w_rdata [2];
    cplx_t           w_wdata;
    cplx_t           w_sel;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_wlast;
    logic            w_rlast;

    assign bus.in_ready  = !w_full[r_wbank];
    assign bus.out_valid = w_full[r_rbank];

    assign w_in_fire  = bus.in_valid  & bus.in_ready;
    assign w_out_fire = bus.out_valid & bus.out_ready;
    assign w_wlast    = (r_wcnt == LOGN'(N - 1));
    assign w_rlast    = (r_rcnt == LOGN'(N - 1));
    assign w_wdata    = {bus.in_re, bus.in_im};

    // Write and read sides touch different flags, so set and clear never collide on one bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_we[b]  = w_in_fire  && (r_wbank == 1'(b));
        assign w_set[b] = w_we[b]    && w_wlast;
        assign w_clr[b] = w_out_fire && (r_rbank == 1'(b)) && w_rlast;

        ifft_pp_bank u_bank (
            .clk        (clk),
            .rst        (rst),
            .i_we       (w_we[b]),
            .i_waddr    (bitrev5(r_wcnt)),
            .i_wdata    (w_wdata),
            .i_set_full (w_set[b]),
            .i_clr_full (w_clr[b]),
            .i_raddr    (r_rcnt),
            .o_rdata    (w_rdata[b]),
            .o_full     (w_full[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
        end else begin
            if (w_in_fire) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (w_wlast) begin
                    r_wbank <= ~r_wbank;
                end
            end
            if (w_out_fire) begin
                r_rcnt <= r_rcnt + 1'b1;
                if (w_rlast) begin
                    r_rbank <= ~r_rbank;
                end
            end
        end
    end

    // Output fields read straight from registered state; zeroed while nothing is offered.
    assign w_sel        = w_rdata[r_rbank];
    assign bus.out_re   = bus.out_valid ? w_sel.re : '0;
    assign bus.out_im   = bus.out_valid ? w_sel.im : '0;
    assign bus.out_idx  = r_rcnt;
    assign bus.out_last = bus.out_valid && w_rlast;

endmodule

// File: tb/tb_ifft_bitrev_reorder.sv
// Directed bench for the bit-reversal reorder stage with a frame-level scoreboard.
module tb_ifft_bitrev_reorder;

    logic clk;
    logic rst;

    ifft_bitrev_reorder_if bus();

    ifft_bitrev_reorder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          in_k;
    int          in_f;
    int          rd_idx;
    int          pops;
    logic [57:0] exp_q[$];
    logic [57:0] fb[32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_rev(input int k);
        logic [4:0] a;
        logic [4:0] r;
        a = 5'(k);
        for (int i = 0; i < 5; i++) r[i] = a[4-i];
        return r;
    endfunction

    // Frame 0: re=k, im=-k. Frame 2 carries the extreme positive/negative values.
    function automatic logic [57:0] gen(input int f, input int k);
        logic [28:0] re;
        logic [28:0] im;
        re = 29'(f * 64 + k);
        im = 29'(-(f * 64 + k));
        if (f == 2 && k == 3) begin
            re = 29'h0FFFFFFF;
            im = 29'h10000000;
        end
        if (f == 2 && k == 4) begin
            re = 29'h10000000;
            im = 29'h0FFFFFFF;
        end
        return {re, im};
    endfunction

    // One clock: drive, check the offered output against the scoreboard, advance, update the model.
    task automatic cyc(input bit want_in, input bit ordy);
        logic [57:0] s;
        bit          in_fire;
        bit          out_fire;
        s             = gen(in_f, in_k);
        bus.in_valid  = want_in;
        bus.in_re     = s[57:29];
        bus.in_im     = s[28:0];
        bus.out_ready = ordy;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                check("out_data", 64'({bus.out_re, bus.out_im}), 64'(exp_q[0]));
                check("out_idx",  64'(bus.out_idx), 64'(rd_idx));
                check("out_last", 64'(bus.out_last), 64'(rd_idx == 31));
            end
        end else begin
            check("idle_data", 64'({bus.out_re, bus.out_im}), 64'd0);
            check("idle_last", 64'(bus.out_last), 64'd0);
        end
        in_fire  = want_in && bus.in_ready;
        out_fire = bus.out_valid && ordy && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        if (out_fire) begin
            void'(exp_q.pop_front());
            rd_idx = (rd_idx + 1) % 32;
            pops++;
        end
        if (in_fire) begin
            fb[ref_rev(in_k)] = s;
            in_k++;
            if (in_k == 32) begin
                for (int i = 0; i < 32; i++) exp_q.push_back(fb[i]);
                in_k = 0;
                in_f++;
            end
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        in_k   = 0;
        rd_idx = 0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_idx",   64'(bus.out_idx),   64'd0);
        check("rst_out_last",  64'(bus.out_last),  64'd0);
        check("rst_out_data",  64'({bus.out_re, bus.out_im}), 64'd0);
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        while (exp_q.size() > 0 && b < budget) begin
            cyc(1'b0, 1'b1);
            b++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bubbles;
        int          budget;
        int          f_target;
        bit          seen;
        bit          rdy;
        bit          held;
        logic [63:0] held_val;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        in_k = 0; in_f = 0; rd_idx = 0; pops = 0;
        repeat (2) @(posedge clk);
        do_reset();

        // Single frame, latency and natural ordering.
        for (int k = 0; k < 32; k++) cyc(1'b1, 1'b1);
        check("lat_valid",   64'(bus.out_valid), 64'd1);
        check("lat_first_re", 64'(bus.out_re),   64'd0);
        check("lat_first_idx", 64'(bus.out_idx), 64'd0);
        drain(64);

        // Three back-to-back frames at full rate.
        pops = 0; bubbles = 0; seen = 1'b0;
        for (int i = 0; i < 96; i++) begin
            check("fr_in_ready", 64'(bus.in_ready), 64'd1);
            if (seen && !bus.out_valid) bubbles++;
            if (bus.out_valid) seen = 1'b1;
            cyc(1'b1, 1'b1);
        end
        budget = 0;
        while (pops < 96 && budget < 100) begin
            if (!bus.out_valid) bubbles++;
            cyc(1'b0, 1'b1);
            budget++;
        end
        check("fr_pops",    64'(pops),    64'd96);
        check("fr_bubbles", 64'(bubbles), 64'd0);

        // Backpressure: two frames fill both banks, further input refused.
        for (int i = 0; i < 64; i++) begin
            check("bp_in_ready", 64'(bus.in_ready), 64'd1);
            cyc(1'b1, 1'b0);
        end
        check("bp_full_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        check("bp_still_full", 64'(bus.in_ready), 64'd0);
        check("bp_idx_held",   64'(bus.out_idx),  64'd0);
        pops = 0; budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            check("bp_release", 64'(bus.in_ready), 64'(pops >= 32));
            cyc(1'b0, 1'b1);
            budget++;
        end
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_ready_end", 64'(bus.in_ready), 64'd1);

        // Random output stalls; offered sample must hold while stalled.
        f_target = in_f + 2; budget = 0;
        while ((in_f < f_target || exp_q.size() > 0) && budget < 1000) begin
            rdy      = ($urandom_range(0, 99) >= 30);
            held     = bus.out_valid && !rdy;
            held_val = 64'({bus.out_idx, bus.out_re, bus.out_im});
            cyc(in_f < f_target, rdy);
            if (held) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_hold", 64'({bus.out_idx, bus.out_re, bus.out_im}), held_val);
            end
            budget++;
        end
        check("stall_done", 64'(exp_q.size()), 64'd0);

        // Reset mid input frame, then reset mid read.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
        check("mid_read_idx", 64'(bus.out_idx), 64'd5);
        do_reset();
        cyc(1'b0, 1'b1);
        check("post_rst_quiet", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1);
        check("post_rst_valid", 64'(bus.out_valid), 64'd1);
        check("post_rst_idx",   64'(bus.out_idx),   64'd0);
        drain(64);

        // Random input gaps combined with random output stalls.
        f_target = in_f + 2; budget = 0;
        while ((in_f < f_target || exp_q.size() > 0) && budget < 1000) begin
            cyc((in_f < f_target) && ($urandom_range(0, 99) < 60), $urandom_range(0, 99) >= 30);
            budget++;
        end
        check("gap_done", 64'(exp_q.size()), 64'd0);
        check("gap_end_ready", 64'(bus.in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifft_bitrev_reorder.md
Name: ifft_bitrev_reorder

Overview:
- Output stage directly downstream of the 32-point IFFT sample buffer.
- Accepts complex IFFT results, which arrive in bit-reversed index order, one sample per accepted beat.
- Re-emits each 32-sample frame in natural order (index 0..31) under a valid/ready handshake.
- Ping-pong double buffer: one frame is written while the previous frame is read, so sustained full rate is possible.

Parameters:
- DW, 29, width of each real and imaginary component, two's complement.
- N, 32, points per frame; must equal 2**LOGN.
- LOGN, 5, index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept an input sample.
- in_re  in  DW  input real part, sample k of the bit-reversed stream.
- in_im  in  DW  input imaginary part.
- out_valid  out  1  output sample present.
- out_ready  in  1  consumer accepts the output sample.
- out_re  out  DW  output real part, natural order.
- out_im  out  DW  output imaginary part.
- out_idx  out  LOGN  natural index of the current output sample.
- out_last  out  1  high while out_idx == N-1 and out_valid.

Behaviour:
- Storage: two banks (0/1), each N x 2 x DW registers. Storage is not reset.
- Control state: wbank, wcnt[LOGN-1:0], rbank, rcnt[LOGN-1:0], full[1:0].
- Reset: all control state = 0; out_valid=0; out_last=0; out_idx=0; out_re=out_im=0; in_ready=1 on the first cycle after reset.
- Reset mid-frame: any partial input frame and any unread frame are discarded; no sample is emitted after reset.
- in_ready = !full[wbank]. It depends on registers only; there is no combinational path from out_ready.
- Write accept (in_valid & in_ready):
  - Store at bank[wbank][bitrev(wcnt)]; bitrev reverses the LOGN bits.
  - wcnt++.
  - If wcnt == N-1: set full[wbank], toggle wbank, wcnt wraps to 0.
- in_valid while !in_ready: sample ignored, no state change. The upstream stage holds it.
- out_valid = full[rbank].
- out_re/out_im = bank[rbank][rcnt] when out_valid, else 0.
- out_idx = rcnt.
- Read accept (out_valid & out_ready):
  - rcnt++.
  - If rcnt == N-1: clear full[rbank], toggle rbank, rcnt wraps to 0.
- Latency: natural sample 0 of a frame is valid in the cycle after the N-th input of that frame is accepted.
- Throughput: with in_valid=1 and out_ready=1 continuously, every cycle accepts one input and emits one output, with no bubbles after the first frame.
- Simultaneous completion: a write completing bank A and a read freeing bank B in the same cycle update independent flags. Both take effect at that edge.
- Full boundary: both banks full gives in_ready=0 until the read of rbank finishes. The freed bank's in_ready rises in the cycle after the last read beat.
- out_valid low with out_ready high: no effect.
- Output data/index must stay stable while out_valid & !out_ready.
- Width rule: pure storage. No arithmetic, scaling or truncation; bit-exact pass-through.

Decomposition:
- Shared package ifft_pkg: constants IFFT_N=32, IFFT_LOGN=5, IFFT_DW=29; typedef cplx_t {re, im} of DW bits; function bitrev5.
- One natural sub-module: ifft_pp_bank, a single ping-pong bank with write port, combinational read port and full flag, instantiated twice.
- The top level holds the counters and bank select.

Test Plan:
- Reset, then one frame where input k carries re=k, im=-k, with out_ready=1 -> out_idx 0..31 emits re=bitrev5(idx), im=-bitrev5(idx); out_last on idx 31; first out_valid exactly 1 cycle after input 31 is accepted.
- Three back-to-back frames at full rate, out_ready=1 -> in_ready never drops; output contiguous for 96 cycles; data bit-exact, including the max/min values 0x0FFFFFFF and 0x10000000.
- out_ready=0 during two complete input frames -> in_ready=0 after 64 accepts; 65th in_valid ignored; raising out_ready gives in_ready=1 one cycle after the 32nd output.
- Random out_ready stall pattern (about 30% stalls) -> out_re/out_im/out_idx held during stalls; no sample is duplicated or lost against the scoreboard.
- rst asserted after 10 inputs of a frame and again while a full frame is mid-read -> next cycle out_valid=0, in_ready=1; a following clean frame is emitted correctly from idx 0.
- Random in_valid gaps -> output order and values are unchanged versus the gap-free run.
